// File: rtl/yc_pattern_gen.sv
// yc_pattern_gen: 15 kHz NTSC/PAL timing with bars, ramp, crosshatch and solid test patterns.
// Ports: clk; reset_n (sync, active-low); pal/range/smpte/pattern/solid_rgb are mode inputs
//   latched at the frame wrap; outputs ce_pix, HBlank/HSync/VBlank/VSync, video_r/g/b, frame_start.
// Option: define YC_PATGEN_ANIM_EN for a white marker column that steps one pixel per frame.
module yc_pattern_gen #(
  parameter int DW        = 8,
  parameter int CE_DIV    = 4,
  parameter int H_ACTIVE  = 720,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 64,
  parameter int H_BP      = 58,
  parameter int V_ACT_N   = 240,
  parameter int V_FP_N    = 3,
  parameter int V_SYNC_N  = 3,
  parameter int V_BP_N    = 16,
  parameter int V_ACT_P   = 288,
  parameter int V_FP_P    = 2,
  parameter int V_SYNC_P  = 3,
  parameter int V_BP_P    = 19,
  parameter int RAMP_STEP = 3,
  parameter int GRID      = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pal,
  input  logic            range,
  input  logic            smpte,
  input  logic [1:0]      pattern,
  input  logic [3*DW-1:0] solid_rgb,
  output logic            ce_pix,
  output logic            HBlank,
  output logic            HSync,
  output logic            VBlank,
  output logic            VSync,
  output logic [DW-1:0]   video_r,
  output logic [DW-1:0]   video_g,
  output logic [DW-1:0]   video_b,
  output logic            frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT_N = V_ACT_N + V_FP_N + V_SYNC_N + V_BP_N;
  localparam int VT_P = V_ACT_P + V_FP_P + V_SYNC_P + V_BP_P;
  localparam int VT_MAX = (VT_N > VT_P) ? VT_N : VT_P;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(VT_MAX);
  localparam int CW = $clog2(CE_DIV);
  localparam int BW = H_ACTIVE / 8;
  localparam int BCW = $clog2(BW + 1);
  localparam int RCW = $clog2(RAMP_STEP + 1);
  localparam int GCW = $clog2(GRID + 1);
  localparam int SH = DW - 8;

  localparam logic [CW-1:0] DIV_M1 = CW'(CE_DIV - 1);
  localparam logic [HW-1:0] HT_M1  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HA     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HA_M1  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS0    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS1    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VTN_M1 = VW'(VT_N - 1);
  localparam logic [VW-1:0] VTP_M1 = VW'(VT_P - 1);
  localparam logic [VW-1:0] VAN    = VW'(V_ACT_N);
  localparam logic [VW-1:0] VAP    = VW'(V_ACT_P);
  localparam logic [VW-1:0] VSN0   = VW'(V_ACT_N + V_FP_N);
  localparam logic [VW-1:0] VSN1   = VW'(V_ACT_N + V_FP_N + V_SYNC_N);
  localparam logic [VW-1:0] VSP0   = VW'(V_ACT_P + V_FP_P);
  localparam logic [VW-1:0] VSP1   = VW'(V_ACT_P + V_FP_P + V_SYNC_P);
  localparam logic [BCW-1:0] BW_M1 = BCW'(BW - 1);
  localparam logic [RCW-1:0] RS_M1 = RCW'(RAMP_STEP - 1);
  localparam logic [GCW-1:0] G_M1  = GCW'(GRID - 1);
  localparam logic [DW-1:0] WHITE  = DW'(255) << SH;
  localparam logic [DW-1:0] L75    = DW'(191) << SH;
  localparam logic [DW-1:0] OFS    = DW'(16) << SH;

  logic [CW-1:0]   div_q, div_d;
  logic            ce_pix_q, ce_pix_d;
  logic [HW-1:0]   hc_q, hc_d;
  logic [VW-1:0]   vc_q, vc_d;
  logic            pal_q, pal_d, rng_q, rng_d, smp_q, smp_d;
  logic [1:0]      pat_q, pat_d;
  logic [3*DW-1:0] sol_q, sol_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic [7:0]      grey_q, grey_d;
  logic [GCW-1:0]  gh_q, gh_d, gv_q, gv_d;
  logic            hb_q, hb_d, hs_q, hs_d, vb_q, vb_d, vs_q, vs_d;
  logic [DW-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic            fs_q, fs_d;
`ifdef YC_PATGEN_ANIM_EN
  logic [HW-1:0]   mx_q, mx_d;
`endif

  logic            hb, hs, vb, vs, grid_on;
  logic            line_end, v_end;
  logic [VW-1:0]   v_act;
  logic [DW-1:0]   lvl, pr, pg, pb;

  // Limited range: 16 + (v*220)>>8, scaled for DW.
  function automatic logic [DW-1:0] lim(input logic [DW-1:0] v);
    logic [DW+7:0] p;
    p = {8'd0, v} * (DW+8)'(220);
    return OFS + p[DW+7:8];
  endfunction

  // Pixel decode for the current counters; registered on ce_pix.
  always_comb begin
    v_act = pal_q ? VAP : VAN;
    hb = hc_q >= HA;
    hs = (hc_q >= HS0) && (hc_q < HS1);
    vb = vc_q >= v_act;
    vs = pal_q ? ((vc_q >= VSP0) && (vc_q < VSP1))
               : ((vc_q >= VSN0) && (vc_q < VSN1));
    lvl = smp_q ? WHITE : L75;
    grid_on = (gh_q == '0) || (gv_q == '0) || (hc_q == HA_M1) ||
              (vc_q == v_act - 1'b1);
    pr = '0;
    pg = '0;
    pb = '0;
    unique case (1'b1)
      pat_q == 2'd0: begin
        // bar index bits map directly onto absent primaries
        pr = bidx_q[1] ? '0 : lvl;
        pg = bidx_q[2] ? '0 : lvl;
        pb = bidx_q[0] ? '0 : lvl;
      end
      pat_q == 2'd1: begin
        pr = DW'(grey_q) << SH;
        pg = pr;
        pb = pr;
      end
      pat_q == 2'd2: begin
        pr = grid_on ? WHITE : '0;
        pg = pr;
        pb = pr;
      end
      default: begin
        pr = sol_q[3*DW-1:2*DW];
        pg = sol_q[2*DW-1:DW];
        pb = sol_q[DW-1:0];
      end
    endcase
`ifdef YC_PATGEN_ANIM_EN
    if (hc_q == mx_q) begin
      pr = WHITE;
      pg = WHITE;
      pb = WHITE;
    end
`endif
    if (rng_q) begin
      pr = lim(pr);
      pg = lim(pg);
      pb = lim(pb);
    end
    if (hb || vb) begin
      pr = '0;
      pg = '0;
      pb = '0;
    end
  end

  always_comb begin
    div_d = div_q;  hc_d = hc_q;  vc_d = vc_q;
    pal_d = pal_q;  rng_d = rng_q;  smp_d = smp_q;
    pat_d = pat_q;  sol_d = sol_q;
    bcnt_d = bcnt_q;  bidx_d = bidx_q;
    rcnt_d = rcnt_q;  grey_d = grey_q;
    gh_d = gh_q;  gv_d = gv_q;
    hb_d = hb_q;  hs_d = hs_q;  vb_d = vb_q;  vs_d = vs_q;
    r_d = r_q;  g_d = g_q;  b_d = b_q;
`ifdef YC_PATGEN_ANIM_EN
    mx_d = mx_q;
`endif
    line_end = hc_q == HT_M1;
    v_end = vc_q == (pal_q ? VTP_M1 : VTN_M1);

    div_d = ce_pix_q ? '0 : div_q + 1'b1;
    ce_pix_d = div_d == DIV_M1;

    if (ce_pix_q) begin
      hb_d = hb;  hs_d = hs;  vb_d = vb;  vs_d = vs;
      r_d = pr;  g_d = pg;  b_d = pb;
      hc_d = line_end ? '0 : hc_q + 1'b1;
      gh_d = (line_end || gh_q == G_M1) ? '0 : gh_q + 1'b1;
      if (line_end) begin
        bcnt_d = '0;  bidx_d = '0;
        rcnt_d = '0;  grey_d = '0;
        vc_d = v_end ? '0 : vc_q + 1'b1;
        gv_d = (v_end || gv_q == G_M1) ? '0 : gv_q + 1'b1;
      end else begin
        // bar 7 holds to the end of the line and absorbs the remainder
        if (bidx_q != 3'd7) begin
          if (bcnt_q == BW_M1) begin
            bcnt_d = '0;
            bidx_d = bidx_q + 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        if (rcnt_q == RS_M1) begin
          rcnt_d = '0;
          if (grey_q != 8'hFF) grey_d = grey_q + 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      if (line_end && v_end) begin
        pal_d = pal;  rng_d = range;  smp_d = smpte;
        pat_d = pattern;  sol_d = solid_rgb;
`ifdef YC_PATGEN_ANIM_EN
        mx_d = (mx_q == HA_M1) ? '0 : mx_q + 1'b1;
`endif
      end
    end
    fs_d = ce_pix_d && (hc_d == '0) && (vc_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;  ce_pix_q <= 1'b0;  hc_q <= '0;  vc_q <= '0;
      pal_q <= 1'b0;  rng_q <= 1'b0;  smp_q <= 1'b0;
      pat_q <= '0;  sol_q <= '0;
      bcnt_q <= '0;  bidx_q <= '0;  rcnt_q <= '0;  grey_q <= '0;
      gh_q <= '0;  gv_q <= '0;
      hb_q <= 1'b0;  hs_q <= 1'b0;  vb_q <= 1'b0;  vs_q <= 1'b0;
      r_q <= '0;  g_q <= '0;  b_q <= '0;  fs_q <= 1'b0;
`ifdef YC_PATGEN_ANIM_EN
      mx_q <= '0;
`endif
    end else begin
      div_q <= div_d;  ce_pix_q <= ce_pix_d;  hc_q <= hc_d;  vc_q <= vc_d;
      pal_q <= pal_d;  rng_q <= rng_d;  smp_q <= smp_d;
      pat_q <= pat_d;  sol_q <= sol_d;
      bcnt_q <= bcnt_d;  bidx_q <= bidx_d;  rcnt_q <= rcnt_d;  grey_q <= grey_d;
      gh_q <= gh_d;  gv_q <= gv_d;
      hb_q <= hb_d;  hs_q <= hs_d;  vb_q <= vb_d;  vs_q <= vs_d;
      r_q <= r_d;  g_q <= g_d;  b_q <= b_d;  fs_q <= fs_d;
`ifdef YC_PATGEN_ANIM_EN
      mx_q <= mx_d;
`endif
    end
  end

  assign ce_pix = ce_pix_q;
  assign HBlank = hb_q;
  assign HSync = hs_q;
  assign VBlank = vb_q;
  assign VSync = vs_q;
  assign video_r = r_q;
  assign video_g = g_q;
  assign video_b = b_q;
  assign frame_start = fs_q;

endmodule
